// File: rtl/ddr_idx_reader.sv
// Fetches a job's index beats from DDR in credit-limited bursts; streams them out of a FWFT FIFO (1 cycle rd_data->ddr_valid).
// Backpressure: requests wait for FIFO credit; rd_data_ready drops when full. DDR_IDX_READER_STAT_EN adds stat_stall.
module ddr_idx_reader #(
  parameter int DDR_W      = 512,
  parameter int IDX_W      = 16,
  parameter int IDX_BATCH  = DDR_W / IDX_W / 2,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int RA_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             done,
  input  logic [RA_W-1:0]  conf_base_addr,
  input  logic [7:0]       conf_idx_num,
  output logic [RA_W-1:0]  rd_addr,
  output logic [7:0]       rd_len,
  output logic             rd_req_valid,
  input  logic             rd_req_ready,
  input  logic [DDR_W-1:0] rd_data,
  input  logic             rd_data_valid,
  output logic             rd_data_ready,
  output logic [DDR_W-1:0] ddr_data,
  output logic             ddr_valid,
  input  logic             ddr_ready
`ifdef DDR_IDX_READER_STAT_EN
  ,
  output logic [15:0]      stat_stall
`endif
);

  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int CW       = PW + 1;
  localparam int BATCH_SH = $clog2(IDX_BATCH);
  localparam int STRIDE   = MAX_BURST * (DDR_W / 8);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [8:0]        total;
  logic [8:0]        req_cnt;
  logic [8:0]        rcv_cnt;
  logic [8:0]        rcv_nxt;
  logic [8:0]        remain;
  logic [8:0]        len;
  logic [RA_W-1:0]   nxt_addr;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     fifo_count_nxt;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_nxt;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DDR_W-1:0]  mem [FIFO_DEPTH];
  logic              start_ok;
  logic              req_hs;
  logic              push;
  logic              pop;
  logic              full;
  logic              credit_ok;
  logic              issue;

  assign start_ok = start && (state == IDLE);
  assign req_hs   = rd_req_valid && rd_req_ready;
  assign push     = rd_data_valid && rd_data_ready;
  assign pop      = ddr_valid && ddr_ready;
  assign full     = (fifo_count == CW'(FIFO_DEPTH));

  assign remain = total - req_cnt;
  assign len    = (remain > 9'(MAX_BURST)) ? 9'(MAX_BURST) : remain;

  // Credit covers both queued beats and beats already promised by earlier bursts.
  assign credit_ok = (16'(fifo_count) + 16'(outstanding) + 16'(len)) <= 16'(FIFO_DEPTH);
  assign issue     = (state == REQ) && !rd_req_valid && (req_cnt != total) && credit_ok;

  assign fifo_count_nxt  = fifo_count + CW'(push) - CW'(pop);
  assign outstanding_nxt = outstanding + (req_hs ? CW'(len) : CW'(0)) - CW'(push);
  assign rcv_nxt         = rcv_cnt + 9'(push);

  assign ddr_valid = (fifo_count != '0);
  assign ddr_data  = ddr_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    done          = 1'b0;
    rd_data_ready = 1'b0;
    case (state)
      IDLE: begin
        done = 1'b1;
        if (start) state_nxt = REQ;
      end
      REQ: begin
        rd_data_ready = !full;
        if (req_hs && ((req_cnt + len) == total)) state_nxt = WAIT;
      end
      WAIT: begin
        rd_data_ready = !full;
        if (rcv_nxt == total) state_nxt = DRAIN;
      end
      DRAIN: begin
        rd_data_ready = !full;
        // Leave as the last beat pops so done rises the following cycle.
        if (fifo_count_nxt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      total <= '0;
    end else if (start_ok) begin
      total <= 9'(conf_idx_num >> BATCH_SH) + 9'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_req_valid <= 1'b0;
      rd_addr      <= '0;
      rd_len       <= '0;
      nxt_addr     <= '0;
      req_cnt      <= '0;
    end else if (start_ok) begin
      nxt_addr <= conf_base_addr;
      req_cnt  <= '0;
    end else if (req_hs) begin
      rd_req_valid <= 1'b0;
      nxt_addr     <= nxt_addr + RA_W'(STRIDE);
      req_cnt      <= req_cnt + len;
    end else if (issue) begin
      rd_req_valid <= 1'b1;
      rd_addr      <= nxt_addr;
      rd_len       <= 8'(len - 9'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_count  <= '0;
      outstanding <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rcv_cnt     <= '0;
    end else begin
      fifo_count  <= fifo_count_nxt;
      outstanding <= outstanding_nxt;
      rcv_cnt     <= start_ok ? 9'd0 : rcv_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rd_data;
  end

`ifdef DDR_IDX_READER_STAT_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      stat_stall <= '0;
    end else if (ddr_valid && !ddr_ready && (stat_stall != 16'hFFFF)) begin
      stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: doc/ddr_idx_reader.md
DDR_IDX_READER -- requirements
Module: ddr_idx_reader

Interface
REQ-001 The block SHALL take parameters: IDX_BATCH, default DDR_W/IDX_W/2, indices per DDR beat (power of two); MAX_BURST, default 16, max beats per read request; FIFO_DEPTH, default 32, stream FIFO entries (>= MAX_BURST, power of two); RA_W, default 32, byte address width.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle job launch.
- done  out  1  high when idle or job complete.
- conf_base_addr  in  RA_W  byte address of first index beat.
- conf_idx_num  in  8  index count minus one.
- rd_addr  out  RA_W  burst byte address.
- rd_len  out  8  burst beats minus one.
- rd_req_valid  out  1  request valid.
- rd_req_ready  in  1  request accepted.
- rd_data  in  DDR_W  returned beat.
- rd_data_valid  in  1  beat valid.
- rd_data_ready  out  1  beat accepted.
- ddr_data  out  DDR_W  stream beat to the index-buffer loader.
- ddr_valid  out  1  stream beat valid.
- ddr_ready  in  1  stream beat consumed.

Function
REQ-003 On start with done=1, the block SHALL latch config, compute TOTAL = floor(conf_idx_num/IDX_BATCH)+1 beats, and clear done next cycle; start while done=0 SHALL be ignored.
REQ-004 FSM states SHALL be IDLE, REQ, WAIT, DRAIN; IDLE->REQ on accepted start; REQ->WAIT when all TOTAL beats are requested; WAIT->DRAIN when all TOTAL beats are received; DRAIN->IDLE when the FIFO empties; done=1 only in IDLE.
REQ-005 Each request SHALL carry LEN = min(MAX_BURST, beats not yet requested), rd_len = LEN-1, rd_addr = conf_base_addr + k*MAX_BURST*(DDR_W/8) for the k-th burst (k from 0), modulo 2^RA_W.
REQ-006 rd_req_valid SHALL assert in REQ only when FIFO_DEPTH - fifo_count - outstanding_beats >= LEN; once asserted, rd_req_valid, rd_addr and rd_len SHALL hold until rd_req_ready.
REQ-007 outstanding_beats SHALL increase by LEN on request handshake and decrease by 1 per rd_data handshake; both in one cycle SHALL net correctly.
REQ-008 rd_data_ready SHALL equal (fifo not full) and be 0 in IDLE; rd_data_valid in IDLE SHALL be dropped without FIFO write.
REQ-009 The FIFO SHALL be first-word-fall-through: ddr_valid = not empty, ddr_data = head entry, pop on ddr_valid&&ddr_ready; simultaneous push and pop SHALL leave count unchanged; data SHALL leave in arrival order, unmodified.
REQ-010 Latency from rd_data handshake to ddr_valid SHALL be one cycle with an empty FIFO.
REQ-011 ddr_data SHALL remain stable while ddr_valid=1 and ddr_ready=0.
REQ-012 done SHALL rise the cycle after the TOTAL-th beat pops.

Reset
REQ-013 rst SHALL force IDLE, done=1, rd_req_valid=0, rd_data_ready=0, ddr_valid=0, FIFO empty, outstanding_beats=0; rd_addr, rd_len, ddr_data SHALL reset to 0.
REQ-014 rst mid-job SHALL abort immediately, discarding queued and in-flight beats; start in the rst cycle SHALL be ignored.

Configuration
REQ-015 With macro DDR_IDX_READER_STAT_EN defined, the block SHALL add output stat_stall  out  16, counting cycles with ddr_valid=1 and ddr_ready=0, saturating at 16'hFFFF, cleared to 0 on accepted start and on rst; without the macro the port and counter SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-016 Bench (IDX_BATCH=8, MAX_BURST=4, FIFO_DEPTH=8, 64-byte beats) SHALL cover:
- base=0x1000, idx_num=7, ready always high -> one request addr 0x1000 len 0; one ddr beat; done rises next cycle after pop.
- idx_num=79 -> TOTAL=10; requests 0x1000/len3, 0x1100/len3, 0x1200/len1; 10 beats in order.
- idx_num=79, ddr_ready held low -> requests stop once credit is exhausted (two len3 requests, FIFO full at 8); no overflow; all 10 beats delivered when ddr_ready released.
- rd_req_ready low 5 cycles -> rd_req_valid/addr/len held constant throughout.
- rst during WAIT with 3 beats queued -> next cycle done=1, ddr_valid=0; later rd_data_valid beats ignored; fresh start completes normally.
- With DDR_IDX_READER_STAT_EN: 6 backpressured cycles on a valid head -> stat_stall=6; next start -> 0.
